// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side initiator for the single-port synchronous accelerator RAM
//   (1-cycle registered read latency). Takes a burst command, issues
//   sequential read addresses, captures the returned words in a 2-entry
//   buffer and streams them out on a valid/ready interface.
//
// Optional feature macro: RAM_BURST_STRIDE_EN
//   defined   : cmd_stride port present; address increment = latched stride
//   undefined : no cmd_stride port; address increment fixed at 1
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_addr, cmd_len     burst base address and length in words (0 = empty)
//   cmd_stride            address increment (RAM_BURST_STRIDE_EN only)
//   ram_addr/we/din/dout  RAM port; write side tied off
//   out_valid/ready/data  output word stream, out_last marks final beat
//   busy                  high while a burst is in RUN or DRAIN
//   done                  one-cycle pulse after burst completion
module ram_burst_reader #(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
`ifdef RAM_BURST_STRIDE_EN
   input  logic [AW-1:0] cmd_stride,
`endif
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [LW-1:0] LEN_ONE = LW'(1);

   state_t          state_q, state_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [LW-1:0]   remain_q, remain_d;
   logic            inflight_q, inflight_d;
   logic            inflight_last_q, inflight_last_d;
   logic            head_valid_q, head_valid_d;
   logic [DW-1:0]   head_data_q, head_data_d;
   logic            head_last_q, head_last_d;
   logic            tail_valid_q, tail_valid_d;
   logic [DW-1:0]   tail_data_q, tail_data_d;
   logic            tail_last_q, tail_last_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            cmd_ready_q, cmd_ready_d;

   logic [AW-1:0]   incr_s;
   logic            pop_s;
   logic            accept_s;
   logic [1:0]      occ_s;
   logic            issue_s;

`ifdef RAM_BURST_STRIDE_EN
   logic [AW-1:0]   stride_q, stride_d;

   // Stride is captured at command accept and held for the whole burst
   always_comb begin
      stride_d = stride_q;
      if (accept_s) begin
         stride_d = cmd_stride;
      end else begin
         stride_d = stride_q;
      end
   end

   // Stride register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stride_q <= '0;
      end else begin
         stride_q <= stride_d;
      end
   end

   assign incr_s = stride_q;
`else
   assign incr_s = AW'(1);
`endif

   assign accept_s = cmd_valid & cmd_ready_q;
   assign pop_s    = head_valid_q & out_ready;
   assign occ_s    = {1'b0, head_valid_q} + {1'b0, tail_valid_q};
   // Issue only if the word it returns is guaranteed a buffer slot:
   // occupancy + inflight - pop < 2, rearranged to stay non-negative.
   assign issue_s  = (state_q == RUN) &&
                     (({1'b0, occ_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));

   // Next-state, address/length bookkeeping and completion pulse
   always_comb begin
      state_d         = state_q;
      ram_addr_d      = ram_addr_q;
      remain_d        = remain_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = RUN;
                  ram_addr_d = cmd_addr;
                  remain_d   = cmd_len;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (issue_s) begin
               ram_addr_d      = ram_addr_q + incr_s;
               remain_d        = remain_q - LEN_ONE;
               inflight_d      = 1'b1;
               inflight_last_d = (remain_q == LEN_ONE);
               if (remain_q == LEN_ONE) begin
                  state_d = DRAIN;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (pop_s && head_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d      = (state_d != IDLE);
      cmd_ready_d = (state_d == IDLE);
   end

   // Return buffer: pop first (tail slides to head), then capture the word
   // returned for last cycle's issue into the first free slot.
   always_comb begin
      head_valid_d = head_valid_q;
      head_data_d  = head_data_q;
      head_last_d  = head_last_q;
      tail_valid_d = tail_valid_q;
      tail_data_d  = tail_data_q;
      tail_last_d  = tail_last_q;
      if (pop_s) begin
         head_valid_d = tail_valid_q;
         head_data_d  = tail_data_q;
         head_last_d  = tail_last_q;
         tail_valid_d = 1'b0;
      end else begin
         tail_valid_d = tail_valid_q;
      end
      if (inflight_q) begin
         if (!head_valid_d) begin
            head_valid_d = 1'b1;
            head_data_d  = ram_dout;
            head_last_d  = inflight_last_q;
         end else begin
            tail_valid_d = 1'b1;
            tail_data_d  = ram_dout;
            tail_last_d  = inflight_last_q;
         end
      end else begin
         tail_last_d = tail_last_d;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         ram_addr_q      <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         head_valid_q    <= 1'b0;
         head_data_q     <= '0;
         head_last_q     <= 1'b0;
         tail_valid_q    <= 1'b0;
         tail_data_q     <= '0;
         tail_last_q     <= 1'b0;
         done_q          <= 1'b0;
         busy_q          <= 1'b0;
         cmd_ready_q     <= 1'b1;
      end else begin
         state_q         <= state_d;
         ram_addr_q      <= ram_addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         head_valid_q    <= head_valid_d;
         head_data_q     <= head_data_d;
         head_last_q     <= head_last_d;
         tail_valid_q    <= tail_valid_d;
         tail_data_q     <= tail_data_d;
         tail_last_q     <= tail_last_d;
         done_q          <= done_d;
         busy_q          <= busy_d;
         cmd_ready_q     <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = 1'b0;
   assign ram_din   = '0;
   assign out_valid = head_valid_q;
   assign out_data  = head_data_q;
   assign out_last  = head_valid_q & head_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
